// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the E stage. It holds the architectural
// HI/LO registers. mult/multu/div/divu compute their full result when start is
// accepted, then stay busy for a fixed latency before committing to HI/LO.
// mthi/mtlo write HI/LO at once.
//
// Handshake: start is a one-cycle request and is accepted only in IDLE. While
// busy is high every start is dropped and latches err_start_busy, because the
// hazard unit is expected to stall MDU-class instructions on start|busy.
// busy is registered, and it is high exactly while the FSM is in RUN.
module md_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             err_start_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;

  // Full-width products. The operands are extended to 2*WIDTH before the
  // multiply, so the low 2*WIDTH bits are the exact signed or unsigned product.
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // The divisor is forced to 1 for divide-by-zero and for most-negative / -1.
  // Both cases are resolved explicitly below, so the divider never sees them.
  logic                    div_zero;
  logic                    div_ovf;
  logic signed [WIDTH-1:0] sa;
  logic signed [WIDTH-1:0] sb_safe;
  logic signed [WIDTH-1:0] q_s;
  logic signed [WIDTH-1:0] r_s;
  logic        [WIDTH-1:0] ub_safe;
  logic        [WIDTH-1:0] q_u;
  logic        [WIDTH-1:0] r_u;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);
  assign sa       = $signed(a);
  assign sb_safe  = (div_zero || div_ovf) ? WIDTH'(1) : $signed(b);
  assign q_s      = sa / sb_safe;
  assign r_s      = sa % sb_safe;
  assign ub_safe  = div_zero ? WIDTH'(1) : b;
  assign q_u      = a / ub_safe;
  assign r_u      = a % ub_safe;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [CW-1:0]    lat;

  // Select the result and the latency for the requested operation.
  // A division by zero keeps the current HI/LO as its result.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    lat    = CW'(MULT_CYCLES);
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        lat = CW'(DIV_CYCLES);
        if (div_ovf) begin
          res_lo = MOST_NEG;
          res_hi = '0;
        end else if (!div_zero) begin
          res_lo = q_s;
          res_hi = r_s;
        end
      end
      OP_DIVU: begin
        lat = CW'(DIV_CYCLES);
        if (!div_zero) begin
          res_lo = q_u;
          res_hi = r_u;
        end
      end
      default: ;
    endcase
  end

  // Control FSM: IDLE accepts requests; RUN counts down the latency and then commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      count          <= '0;
      hi             <= '0;
      lo             <= '0;
      pend_hi        <= '0;
      pend_lo        <= '0;
      err_start_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                count   <= lat;
                state   <= RUN;
                busy    <= 1'b1;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (start) err_start_busy <= 1'b1;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: checks md_unit against a cycle-level reference model. The model
// gives each operation a fixed number of busy cycles and pops the expected
// result from a queue when that time is up. A compare process checks busy,
// hi, lo and err_start_busy on every falling edge. Directed cases also check
// hand-computed literal values.
module tb_md_unit;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err_start_busy;

  int total  = 0;
  int passed = 0;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .err_start_busy(err_start_busy)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Reference arithmetic. It works at 64 bits and returns {hi, lo}.
  // cur is the current {hi, lo}, kept unchanged on a division by zero.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] cur);
    longint p, q, r, sx, sy;
    logic [63:0] res;
    res = cur;
    case (o)
      3'd1: begin
        p   = longint'($signed(x)) * longint'($signed(y));
        res = p;
      end
      3'd2: res = {32'b0, x} * {32'b0, y};
      3'd3: if (y != 0) begin
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        q   = sx / sy;
        r   = sx - q * sy;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (y != 0) begin
        sx  = longint'({32'b0, x});
        sy  = longint'({32'b0, y});
        q   = sx / sy;
        r   = sx - q * sy;
        res = {r[31:0], q[31:0]};
      end
      default: ;
    endcase
    return res;
  endfunction

  // Model state. exp_q holds the pending commit; m_left counts busy cycles left.
  logic [63:0] exp_q[$];
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_err  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_err  = 1'b0;
      exp_q.delete();
    end else if (m_left > 0) begin
      if (start) m_err = 1'b1;
      m_left--;
      if (m_left == 0 && exp_q.size() > 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (start) begin
      case (op)
        3'd1, 3'd2: begin
          exp_q.push_back(ref_result(op, a, b, {m_hi, m_lo}));
          m_left = 5;
        end
        3'd3, 3'd4: begin
          exp_q.push_back(ref_result(op, a, b, {m_hi, m_lo}));
          m_left = 10;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("err_start_busy", 32'(err_start_busy), 32'(m_err));
  end

  // Driver: a one-cycle start pulse. It returns in the first cycle after the capture edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); #1;
    start = 1'b0; op = 3'd0;
  endtask

  // Count busy cycles from the current one. The count is bounded so a stuck busy cannot hang.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    // reset
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_err", 32'(err_start_busy), 32'd0);
    reset = 1'b1;

    // mult -2 * 3
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // mthi/mtlo, then divu by zero
    issue(3'd5, 32'h11, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    chk("mtlo_lo", lo, 32'h22);
    issue(3'd4, 32'd7, 32'd0);
    count_busy(n);
    chk("divz_cycles", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);

    // start during RUN of a div is ignored and flagged
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk); #1;
    @(negedge clk); #1;
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd5;
    @(negedge clk); #1;
    start = 1'b0; op = 3'd0;
    count_busy(n);
    chk("viol_cycles", 32'(n), 32'd7);
    chk("viol_lo", lo, 32'd14);
    chk("viol_hi", hi, 32'd2);
    chk("viol_err", 32'(err_start_busy), 32'd1);

    // signed overflow
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // randomized traffic, including back-to-back requests and reserved ops
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      start = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      @(negedge clk); #1;
      start = 1'b0;
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    @(negedge clk); #1;
    count_busy(n);

    // asynchronous reset in RUN cycle 3 of a mult
    issue(3'd6, 32'h77, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    @(negedge clk); #1;
    @(negedge clk); #1;
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_err", 32'(err_start_busy), 32'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    issue(3'd6, 32'd5, 32'd0);
    chk("post_mtlo_lo", lo, 32'd5);
    chk("post_mtlo_busy", 32'(busy), 32'd0);
    chk("post_mtlo_hi", hi, 32'd0);
    repeat (3) @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
